move_request_scheduler: RTL

- Sequences the green-square movement datapath: turns raw pushbutton presses into one latched direction and issues one-cycle step strobes on each movement tick.
- Suppresses steps the datapath reports as blocked (walls or obstacle region), counts stalls, and emits a home pulse when the mode switch drops.
- Sits between board pushbuttons / mode switch and the square position register; all logic runs in the fast system clock domain.

---
 rtl/move_request_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/move_request_scheduler.sv
// Turns synchronized pushbutton presses into a latched one-hot direction and issues
// one-cycle step strobes on movement ticks, with stall counting and a home pulse on disable.
module move_request_scheduler #(
  parameter int SYNC_STAGES = 2,
  parameter int STICKY      = 1,
  parameter int STALL_W     = 8
) (
  input  logic               clock_25Mhz,
  input  logic               reset,
  input  logic               switch,
  input  logic [3:0]         pb,
  input  logic               tick_move,
  input  logic [3:0]         blocked,
  output logic [3:0]         dir,
  output logic [3:0]         step,
  output logic               home,
  output logic [1:0]         state_o,
  output logic [STALL_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_MOVING   = 2'd2,
    ST_BLOCKED  = 2'd3
  } state_t;

  logic [3:0]             pb_sync_reg [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] sw_sync_reg;
  logic [3:0]             pb_prev_reg;
  logic [3:0]             dir_reg;
  logic [3:0]             step_reg;
  logic                   home_reg;
  logic [STALL_W-1:0]     stall_reg;
  state_t                 state_reg;

  logic [3:0] pb_s;
  logic       sw_s;
  logic [3:0] rise;
  logic [3:0] new_press;
  logic [3:0] dir_next;

  always_ff @(posedge clock_25Mhz) begin
    if (reset) begin
      pb_sync_reg[0] <= '0;
      sw_sync_reg[0] <= 1'b0;
    end else begin
      pb_sync_reg[0] <= pb;
      sw_sync_reg[0] <= switch;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clock_25Mhz) begin
        if (reset) begin
          pb_sync_reg[gi] <= '0;
          sw_sync_reg[gi] <= 1'b0;
        end else begin
          pb_sync_reg[gi] <= pb_sync_reg[gi-1];
          sw_sync_reg[gi] <= sw_sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign pb_s      = pb_sync_reg[SYNC_STAGES-1];
  assign sw_s      = sw_sync_reg[SYNC_STAGES-1];
  assign rise      = pb_s & ~pb_prev_reg;
  // Isolate the lowest rising bit so up beats down beats left beats right.
  assign new_press = rise & 4'(~rise + 4'd1);

  always_comb begin
    dir_next = dir_reg;
    if (new_press != 4'd0 && new_press != dir_reg)
      dir_next = new_press;
    else if (STICKY == 0 && (dir_reg & ~pb_s) != 4'd0)
      dir_next = 4'd0;
  end

  always_ff @(posedge clock_25Mhz) begin
    if (reset) begin
      pb_prev_reg <= '0;
      dir_reg     <= '0;
      step_reg    <= '0;
      home_reg    <= 1'b0;
      stall_reg   <= '0;
      state_reg   <= ST_DISABLED;
    end else begin
      pb_prev_reg <= pb_s;
      step_reg    <= '0;
      home_reg    <= 1'b0;
      if (state_reg == ST_DISABLED) begin
        if (sw_s)
          state_reg <= ST_IDLE;
      end else if (!sw_s) begin
        // Disable wins over any tick or press arriving on the same edge.
        state_reg <= ST_DISABLED;
        home_reg  <= 1'b1;
        dir_reg   <= '0;
        stall_reg <= '0;
      end else begin
        if (tick_move && (state_reg == ST_MOVING || state_reg == ST_BLOCKED)
            && dir_reg != 4'd0) begin
          if ((blocked & dir_reg) == 4'd0) begin
            step_reg  <= dir_reg;
            state_reg <= ST_MOVING;
            stall_reg <= '0;
          end else begin
            state_reg <= ST_BLOCKED;
            if (stall_reg != '1)
              stall_reg <= stall_reg + 1'b1;
          end
        end
        if (dir_next != dir_reg) begin
          dir_reg   <= dir_next;
          stall_reg <= '0;
          if (dir_next == 4'd0)
            state_reg <= ST_IDLE;
          else if (state_reg == ST_IDLE)
            state_reg <= ST_MOVING;
        end
      end
    end
  end

  assign dir         = dir_reg;
  assign step        = step_reg;
  assign home        = home_reg;
  assign state_o     = state_reg;
  assign stall_count = stall_reg;

endmodule
